// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes and the fetch-unit run state.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'd0;
  localparam logic [3:0] INOP    = 4'd1;
  localparam logic [3:0] IRRMOVQ = 4'd2;
  localparam logic [3:0] IIRMOVQ = 4'd3;
  localparam logic [3:0] IRMMOVQ = 4'd4;
  localparam logic [3:0] IMRMOVQ = 4'd5;
  localparam logic [3:0] IOPQ    = 4'd6;
  localparam logic [3:0] IJXX    = 4'd7;
  localparam logic [3:0] ICALL   = 4'd8;
  localparam logic [3:0] IRET    = 4'd9;
  localparam logic [3:0] IPUSHQ  = 4'd10;
  localparam logic [3:0] IPOPQ   = 4'd11;

  typedef enum logic {
    StRun,
    StHalt
  } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              din,
  output logic [ADDR_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] Full = CW'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // ptr_q points at the next free slot; wrap-around is free for power-of-two depths.
  assign top   = mem_q[ptr_q - PW'(1)];
  assign count = count_q;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d   = ptr_q + PW'(1);
      count_d = (count_q == Full) ? Full : count_q + CW'(1);
    end else if (pop && count_q != '0) begin
      ptr_d   = ptr_q - PW'(1);
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Y86 fetch PC selection: redirect correction, taken-jump and RAS-based prediction,
// plus the RUN/HALT state of the fetch stage.
module pc_predict_unit
  import y86_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 64,
  parameter int unsigned       RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       f_stall,
  input  logic [3:0]                 f_icode,
  input  logic [ADDR_W-1:0]          f_valc,
  input  logic [ADDR_W-1:0]          f_valp,
  input  logic [3:0]                 m_icode,
  input  logic                       m_cnd,
  input  logic [ADDR_W-1:0]          m_vala,
  input  logic [3:0]                 w_icode,
  input  logic [ADDR_W-1:0]          w_valm,
  input  logic [ADDR_W-1:0]          w_pred,
  output logic [ADDR_W-1:0]          pc,
  output logic                       fetch_en,
  output logic                       halted,
  output logic                       illegal,
  output logic                       redirect,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              illegal_q, illegal_d;
  logic [ADDR_W-1:0] pred_pc;
  logic [ADDR_W-1:0] ras_top;
  logic              w_redir, m_redir, accept, is_stop, ras_push, ras_pop;

  assign w_redir  = (w_icode == IRET) && (w_valm != w_pred);
  assign m_redir  = (m_icode == IJXX) && !m_cnd;
  assign redirect = w_redir || m_redir;
  assign fetch_en = (state_q == StRun);
  assign accept   = fetch_en && !f_stall && !redirect;
  assign is_stop  = (f_icode == IHALT) || (f_icode > IPOPQ);
  assign ras_push = accept && (f_icode == ICALL);
  assign ras_pop  = accept && (f_icode == IRET);

  assign pc      = pc_q;
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (f_valp),
    .top   (ras_top),
    .count (ras_count)
  );

  always_comb begin
    pred_pc = f_valp;
    case (f_icode)
      IJXX, ICALL: pred_pc = f_valc;
      IRET:        pred_pc = (ras_count == '0) ? f_valp : ras_top;
      default:     pred_pc = is_stop ? pc_q : f_valp;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    illegal_d = illegal_q;
    if (w_redir) begin
      pc_d = w_valm;
    end else if (m_redir) begin
      pc_d = m_vala;
    end else if (accept) begin
      pc_d = pred_pc;
    end
    // A redirect also rescues a halt that was only fetched speculatively.
    if (redirect) begin
      state_d   = StRun;
      illegal_d = 1'b0;
    end else if (accept && is_stop) begin
      state_d   = StHalt;
      illegal_d = (f_icode > IPOPQ);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      state_q   <= StRun;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
